// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-GPR 2-bit pending-write counters that stall decode on RAW and counter saturation.
// Define SCOREBOARD_BYPASS_EN to let the final retire of a register feed decode directly instead of stalling.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_valid,
    input  logic [4:0]  ds_rs,
    input  logic        ds_rs_used,
    input  logic [4:0]  ds_rt,
    input  logic        ds_rt_used,
    input  logic        ds_gr_we,
    input  logic [4:0]  ds_dest,
    input  logic        ds_issue,
    input  logic        ws_we,
    input  logic [4:0]  ws_dest,
    input  logic [31:0] ws_wdata,
    input  logic        flush,
    output logic        ds_stall,
    output logic        sb_empty,
    output logic        byp_rs_en,
    output logic        byp_rt_en,
    output logic [31:0] byp_data
);
    logic [1:0]  cnt [1:31];
    logic [1:0]  pend [32];
    logic [31:1] inc, dec, busy;
    logic [1:0]  cnt_rs, cnt_rt, cnt_dest;
    logic        rs_raw, rt_raw, rs_byp, rt_byp, rs_haz, rt_haz, sat_haz, inc_ok;

    // $0 reads as a permanently idle counter so lookups need no special case
    always_comb begin
        pend[0] = 2'd0;
        for (int i = 1; i < 32; i++) pend[i] = cnt[i];
    end

    assign cnt_rs   = pend[ds_rs];
    assign cnt_rt   = pend[ds_rt];
    assign cnt_dest = pend[ds_dest];

    assign rs_raw = ds_valid && ds_rs_used && ds_rs != 5'd0 && cnt_rs != 2'd0;
    assign rt_raw = ds_valid && ds_rt_used && ds_rt != 5'd0 && cnt_rt != 2'd0;

`ifdef SCOREBOARD_BYPASS_EN
    assign rs_byp   = rs_raw && cnt_rs == 2'd1 && ws_we && ws_dest == ds_rs;
    assign rt_byp   = rt_raw && cnt_rt == 2'd1 && ws_we && ws_dest == ds_rt;
    assign byp_data = ws_wdata;
`else
    assign rs_byp   = 1'b0;
    assign rt_byp   = 1'b0;
    assign byp_data = 32'd0;
`endif

    assign byp_rs_en = rs_byp;
    assign byp_rt_en = rt_byp;
    assign rs_haz    = rs_raw && !rs_byp;
    assign rt_haz    = rt_raw && !rt_byp;
    assign sat_haz   = ds_valid && ds_gr_we && ds_dest != 5'd0 && cnt_dest == 2'd3;
    assign ds_stall  = rs_haz || rt_haz || sat_haz;

    // an issue that slips past a stall is dropped; the cnt_dest check keeps a counter from wrapping
    assign inc_ok = ds_issue && !ds_stall && ds_gr_we && ds_dest != 5'd0 && cnt_dest != 2'd3;

    always_comb begin
        inc  = '0;
        dec  = '0;
        busy = '0;
        for (int i = 1; i < 32; i++) begin
            inc[i]  = inc_ok && ds_dest == 5'(i);
            dec[i]  = ws_we && ws_dest == 5'(i) && cnt[i] != 2'd0;
            busy[i] = cnt[i] != 2'd0;
        end
    end

    assign sb_empty = ~|busy;

    always_ff @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (reset || flush)
                cnt[i] <= 2'd0;
            else if (inc[i] && !dec[i])
                cnt[i] <= cnt[i] + 2'd1;
            else if (dec[i] && !inc[i])
                cnt[i] <= cnt[i] - 2'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus against a queue-based scoreboard of expected outputs.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        reset, ds_valid, ds_rs_used, ds_rt_used, ds_gr_we, ds_issue, ws_we, flush;
    logic [4:0]  ds_rs, ds_rt, ds_dest, ws_dest;
    logic [31:0] ws_wdata;
    logic        ds_stall, sb_empty, byp_rs_en, byp_rt_en;
    logic [31:0] byp_data;

    typedef struct {
        logic        stall;
        logic        empty;
        logic        brs;
        logic        brt;
        logic [31:0] bd;
        string       tag;
    } exp_t;

`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    exp_t  q[$];
    int    mc[32];
    logic  model_ok = 1'b0;
    int    errors = 0;
    int    checks = 0;
    string tag = "reset";

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_rs(ds_rs), .ds_rs_used(ds_rs_used),
        .ds_rt(ds_rt), .ds_rt_used(ds_rt_used), .ds_gr_we(ds_gr_we), .ds_dest(ds_dest),
        .ds_issue(ds_issue), .ws_we(ws_we), .ws_dest(ws_dest), .ws_wdata(ws_wdata), .flush(flush),
        .ds_stall(ds_stall), .sb_empty(sb_empty), .byp_rs_en(byp_rs_en), .byp_rt_en(byp_rt_en),
        .byp_data(byp_data)
    );

    always #5 clk = ~clk;

    // a read of r waits while any write to r is outstanding, unless bypass catches its last retire
    function automatic logic reads_blocked(input logic [4:0] r, input logic used);
        logic catch_it;
        catch_it = BYP && mc[r] == 1 && ws_we && ws_dest == r;
        return ds_valid && used && r != 0 && mc[r] > 0 && !catch_it;
    endfunction

    function automatic logic bypassed(input logic [4:0] r, input logic used);
        return BYP && ds_valid && used && r != 0 && mc[r] == 1 && ws_we && ws_dest == r;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   total = 0;
        for (int i = 0; i < 32; i++) total += mc[i];
        e.stall = reads_blocked(ds_rs, ds_rs_used) || reads_blocked(ds_rt, ds_rt_used)
                  || (ds_valid && ds_gr_we && ds_dest != 0 && mc[ds_dest] == 3);
        e.empty = total == 0;
        e.brs   = bypassed(ds_rs, ds_rs_used);
        e.brt   = bypassed(ds_rt, ds_rt_used);
        e.bd    = BYP ? ws_wdata : 32'd0;
        e.tag   = tag;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        logic up, down;
        e = predict();
        if (model_ok) q.push_back(e);
        @(posedge clk);
        if (reset || flush) begin
            foreach (mc[i]) mc[i] = 0;
            if (reset) model_ok = 1'b1;
        end else begin
            up   = ds_issue && !e.stall && ds_gr_we && ds_dest != 0;
            down = ws_we && ws_dest != 0 && mc[ws_dest] > 0;
            if (!(up && down && ds_dest == ws_dest)) begin
                if (up) mc[ds_dest]++;
                if (down) mc[ws_dest]--;
            end
        end
        #1;
    endtask

    task automatic set_ds(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                          input logic rtu, input logic we, input logic [4:0] d, input logic iss);
        ds_valid = v; ds_rs = rs; ds_rs_used = rsu; ds_rt = rt; ds_rt_used = rtu;
        ds_gr_we = we; ds_dest = d; ds_issue = iss;
    endtask

    task automatic set_ws(input logic we, input logic [4:0] d, input logic [31:0] data);
        ws_we = we; ws_dest = d; ws_wdata = data;
    endtask

    task automatic chk(input string name, input exp_t e, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s [%s] @%0t: got %h expected %h", name, e.tag, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ds_stall", e, 32'(ds_stall), 32'(e.stall));
            chk("sb_empty", e, 32'(sb_empty), 32'(e.empty));
            chk("byp_rs_en", e, 32'(byp_rs_en), 32'(e.brs));
            chk("byp_rt_en", e, 32'(byp_rt_en), 32'(e.brt));
            chk("byp_data", e, byp_data, e.bd);
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        set_ds(1, 0, 0, 0, 0, 1, 3, 1);
        set_ws(1, 3, 32'hdead_beef);
        step(); step();
        set_ds(0, 0, 0, 0, 0, 0, 0, 0);
        set_ws(0, 0, 0);
        step();
        reset = 1'b0;
        step();

        tag = "raw_dep";
        set_ds(1, 0, 0, 0, 0, 1, 3, 1); step();
        set_ds(1, 3, 1, 0, 0, 1, 8, 1); step(); step();
        set_ws(1, 3, 32'h1111_0003); step();
        set_ws(0, 0, 0); step(); step();

        tag = "saturate";
        set_ws(1, 8, 0);
        set_ds(1, 0, 0, 0, 0, 1, 5, 1); step();
        set_ws(0, 0, 0); step(); step();
        step(); step();
        set_ws(1, 5, 0); set_ds(0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step(); step();

        tag = "same_cycle";
        set_ws(0, 0, 0);
        set_ds(1, 0, 0, 0, 0, 1, 7, 1); step();
        set_ws(1, 7, 0); step();
        set_ws(0, 0, 0); set_ds(1, 7, 1, 7, 1, 0, 0, 0); step();
        set_ws(1, 7, 0); step();
        set_ws(0, 0, 0); step();

        tag = "reg_zero";
        set_ds(1, 0, 1, 0, 1, 1, 0, 1); step(); step();

        tag = "flush";
        set_ds(1, 0, 0, 0, 0, 1, 4, 1); step(); step();
        set_ds(1, 0, 0, 0, 0, 1, 9, 1); step();
        set_ds(1, 4, 1, 9, 1, 1, 10, 1); set_ws(1, 4, 0); flush = 1'b1; step();
        flush = 1'b0; set_ws(0, 0, 0); step();
        set_ws(1, 4, 0); set_ds(1, 4, 1, 9, 1, 0, 0, 0); step();
        set_ws(0, 0, 0); step();

        tag = "bypass";
        set_ds(1, 0, 0, 0, 0, 1, 6, 1); step();
        set_ds(1, 6, 1, 6, 1, 0, 0, 0); set_ws(1, 6, 32'h1234_5678); step();
        set_ws(0, 0, 0); step();

        tag = "mid_reset";
        set_ds(1, 0, 0, 0, 0, 1, 11, 1); step();
        set_ds(0, 0, 0, 0, 0, 0, 0, 0); reset = 1'b1; step();
        reset = 1'b0; set_ws(1, 11, 0); set_ds(1, 11, 1, 0, 0, 0, 0, 0); step();
        set_ws(0, 0, 0); step();

        tag = "random";
        for (int n = 0; n < 4000; n++) begin
            logic stall_now;
            reset = $urandom_range(0, 199) == 0;
            flush = $urandom_range(0, 63) == 0;
            set_ds($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), 1'b0);
            set_ws($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            stall_now = predict().stall;
            ds_issue = ds_valid && (stall_now ? $urandom_range(0, 7) == 0 : 1'($urandom));
            step();
        end

        reset = 1'b0; flush = 1'b0;
        for (int n = 0; n < 5 && q.size() > 0; n++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
